// File: rtl/udp_frame_originator_pkg.sv
// udp_frame_originator_pkg
//   Shared definitions for the UDP frame originator:
//     - state_e         : top-level FSM state encoding (idle / header / payload)
//     - UDP_HDR_BYTES   : size of the UDP header in bytes
//     - BYTES_PER_WORD  : bytes carried by one 64-bit sample word
//     - DEFAULT_TTL     : IP time-to-live placed in every header
//     - udp_length()    : UDP length field for a given number of payload words
package udp_frame_originator_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHdr     = 2'd1,
        StPayload = 2'd2
    } state_e;

    localparam int unsigned UDP_HDR_BYTES  = 8;
    localparam int unsigned BYTES_PER_WORD = 8;
    localparam logic [7:0]  DEFAULT_TTL    = 8'd64;

    // UDP length = header + payload, truncated to the 16-bit field width.
    function automatic logic [15:0] udp_length(input int unsigned words);
        return 16'(UDP_HDR_BYTES + BYTES_PER_WORD * words);
    endfunction

endpackage

// File: rtl/udp_word_serializer.sv
// udp_word_serializer
//   Holds one 64-bit word and emits it as 8 bytes, byte 0 (bits [7:0]) first,
//   one byte per tvalid && tready cycle. A new word can be loaded in the same
//   cycle the final byte of the current word handshakes, so back-to-back words
//   stream without a bubble.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load word into the holding register (only honoured when can_load)
//   word        : 64-bit word to load
//   word_last   : loaded word is the final word of the datagram (drives tlast)
//   can_load    : holding register empty, or its last byte handshakes this cycle
//   tdata       : current payload byte
//   tvalid      : holding register is occupied
//   tready      : downstream ready
//   tlast       : byte 7 of the final word is on the bus
//   frame_end   : pulse, the tlast byte handshakes this cycle
module udp_word_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] word,
    input  logic        word_last,
    output logic        can_load,
    output logic [7:0]  tdata,
    output logic        tvalid,
    input  logic        tready,
    output logic        tlast,
    output logic        frame_end
);

    logic [63:0] hold_q, hold_d;
    logic        full_q, full_d;
    logic        last_q, last_d;
    logic [2:0]  idx_q,  idx_d;

    logic byte_hs;
    logic word_done;

    assign byte_hs   = full_q && tready;
    assign word_done = byte_hs && (idx_q == 3'd7);
    assign can_load  = !full_q || word_done;
    assign frame_end = word_done && last_q;

    always_comb begin
        tvalid = full_q;
        tdata  = 8'(hold_q >> {idx_q, 3'b000});
        tlast  = full_q && last_q && (idx_q == 3'd7);
    end

    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        last_d = last_q;
        idx_d  = idx_q;

        if (byte_hs) begin
            // Index wraps 7 -> 0 on its own.
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                full_d = 1'b0;
            end
        end

        // A load takes priority over the empty-on-last-byte above.
        if (load && can_load) begin
            hold_d = word;
            full_d = 1'b1;
            last_d = word_last;
            idx_d  = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            full_q <= 1'b0;
            last_q <= 1'b0;
            idx_q  <= 3'd0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
            last_q <= last_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/udp_frame_originator.sv
// udp_frame_originator
//   Packs a stream of 64-bit sample words into UDP datagrams of WORDS_PER_FRAME
//   words. Each datagram is a header handshake followed by a byte payload.
//
//   Optional build macro: UDP_ORIG_SEQNUM_EN
//     When defined, every payload starts with one extra 8-byte word
//     {32'd0, frame_count} (LSB first) ahead of the sample words, and the UDP
//     length grows by 8. When undefined no sequence logic exists.
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready: 64-bit sample word input (no tlast)
//   tx_udp_hdr_valid/ready  : UDP header handshake
//   tx_udp_ip_* / tx_udp_*  : header fields (constant for a given build)
//   tx_udp_payload_axis_*   : byte payload stream, tlast on final byte
//   frame_count             : datagrams completed since reset (wraps)
module udp_frame_originator #(
    parameter int unsigned WORDS_PER_FRAME = 16,
    parameter logic [15:0] SRC_PORT        = 16'd1234,
    parameter logic [15:0] DEST_PORT       = 16'd1234,
    parameter logic [31:0] SRC_IP          = {8'd192, 8'd168, 8'd1, 8'd128},
    parameter logic [31:0] DEST_IP         = {8'd192, 8'd168, 8'd1, 8'd100}
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [63:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,

    output logic        tx_udp_hdr_valid,
    input  logic        tx_udp_hdr_ready,
    output logic [5:0]  tx_udp_ip_dscp,
    output logic [1:0]  tx_udp_ip_ecn,
    output logic [7:0]  tx_udp_ip_ttl,
    output logic [31:0] tx_udp_ip_source_ip,
    output logic [31:0] tx_udp_ip_dest_ip,
    output logic [15:0] tx_udp_source_port,
    output logic [15:0] tx_udp_dest_port,
    output logic [15:0] tx_udp_length,
    output logic [15:0] tx_udp_checksum,

    output logic [7:0]  tx_udp_payload_axis_tdata,
    output logic        tx_udp_payload_axis_tvalid,
    input  logic        tx_udp_payload_axis_tready,
    output logic        tx_udp_payload_axis_tlast,
    output logic        tx_udp_payload_axis_tuser,

    output logic [31:0] frame_count
);

    import udp_frame_originator_pkg::*;

`ifdef UDP_ORIG_SEQNUM_EN
    localparam int unsigned SEQ_WORDS = 1;
`else
    localparam int unsigned SEQ_WORDS = 0;
`endif
    localparam int unsigned TOTAL_WORDS   = WORDS_PER_FRAME + SEQ_WORDS;
    localparam logic [7:0]  TOTAL_WORDS_B = 8'(TOTAL_WORDS);
    localparam logic [7:0]  LAST_WORD_B   = 8'(TOTAL_WORDS - 1);
    localparam logic [15:0] LENGTH        = udp_length(TOTAL_WORDS);

    state_e      state_q, state_d;
    logic [7:0]  word_cnt_q, word_cnt_d;     // words loaded into the serialiser this frame
    logic [31:0] frame_count_q, frame_count_d;
    logic [1:0]  rst_sync_q;

    logic        run_en;
    logic        ser_load;
    logic [63:0] ser_word;
    logic        ser_last;
    logic        ser_can_load;
    logic        ser_frame_end;

    // Reset release is synchronised so the FSM never leaves idle on the
    // cycle rst_n deasserts asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run_en = rst_sync_q[1];

    // Header fields are build-time constants.
    assign tx_udp_ip_dscp      = 6'd0;
    assign tx_udp_ip_ecn       = 2'd0;
    assign tx_udp_ip_ttl       = DEFAULT_TTL;
    assign tx_udp_ip_source_ip = SRC_IP;
    assign tx_udp_ip_dest_ip   = DEST_IP;
    assign tx_udp_source_port  = SRC_PORT;
    assign tx_udp_dest_port    = DEST_PORT;
    assign tx_udp_length       = LENGTH;
    assign tx_udp_checksum     = 16'd0;

    assign tx_udp_payload_axis_tuser = 1'b0;
    assign frame_count               = frame_count_q;

    always_comb begin
        state_d          = state_q;
        word_cnt_d       = word_cnt_q;
        frame_count_d    = frame_count_q;
        tx_udp_hdr_valid = 1'b0;
        s_tready         = 1'b0;
        ser_load         = 1'b0;
        ser_word         = s_tdata;
        ser_last         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run_en && s_tvalid) begin
                    state_d = StHdr;
                end
            end

            StHdr: begin
                tx_udp_hdr_valid = 1'b1;
                if (tx_udp_hdr_ready) begin
                    state_d = StPayload;
                end
            end

            StPayload: begin
                if (word_cnt_q != TOTAL_WORDS_B) begin
`ifdef UDP_ORIG_SEQNUM_EN
                    if (word_cnt_q == 8'd0) begin
                        // Sequence word is sourced internally; input stays blocked.
                        ser_word = {32'd0, frame_count_q};
                        ser_load = ser_can_load;
                    end else begin
                        s_tready = ser_can_load;
                        ser_load = s_tvalid && ser_can_load;
                    end
`else
                    s_tready = ser_can_load;
                    ser_load = s_tvalid && ser_can_load;
`endif
                    ser_last = (word_cnt_q == LAST_WORD_B);
                    if (ser_load) begin
                        word_cnt_d = word_cnt_q + 8'd1;
                    end
                end

                // Final word was loaded earlier, so this never coincides with a load.
                if (ser_frame_end) begin
                    state_d       = StIdle;
                    word_cnt_d    = 8'd0;
                    frame_count_d = frame_count_q + 32'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            word_cnt_q    <= 8'd0;
            frame_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            frame_count_q <= frame_count_d;
        end
    end

    udp_word_serializer u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .word      (ser_word),
        .word_last (ser_last),
        .can_load  (ser_can_load),
        .tdata     (tx_udp_payload_axis_tdata),
        .tvalid    (tx_udp_payload_axis_tvalid),
        .tready    (tx_udp_payload_axis_tready),
        .tlast     (tx_udp_payload_axis_tlast),
        .frame_end (ser_frame_end)
    );

endmodule

// File: tb/tb_udp_frame_originator.sv
// tb_udp_frame_originator
//   Scoreboard bench for udp_frame_originator with WORDS_PER_FRAME = 2.
//   Expected payload bytes are queued as sample words are accepted (and, when
//   UDP_ORIG_SEQNUM_EN is defined, as the header handshakes) and popped as the
//   DUT emits bytes. Header fields and frame_count come from bench constants.
module tb_udp_frame_originator;

    localparam int unsigned W = 2;
`ifdef UDP_ORIG_SEQNUM_EN
    localparam int unsigned SEQ = 1;
`else
    localparam int unsigned SEQ = 0;
`endif
    localparam logic [15:0] EXP_LEN = 16'(8 + 8 * (W + SEQ));

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        hdr_valid;
    logic        hdr_ready = 1'b1;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [7:0]  ttl;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port, udp_len, csum;
    logic [7:0]  pay_tdata;
    logic        pay_tvalid, pay_tready, pay_tlast, pay_tuser;
    logic [31:0] frame_count;

    logic toggle_en = 1'b0;
    logic toggle_ph = 1'b1;
    assign pay_tready = toggle_en ? toggle_ph : 1'b1;

    always #5 clk = ~clk;

    udp_frame_originator #(
        .WORDS_PER_FRAME (W)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .s_tdata                    (s_tdata),
        .s_tvalid                   (s_tvalid),
        .s_tready                   (s_tready),
        .tx_udp_hdr_valid           (hdr_valid),
        .tx_udp_hdr_ready           (hdr_ready),
        .tx_udp_ip_dscp             (dscp),
        .tx_udp_ip_ecn              (ecn),
        .tx_udp_ip_ttl              (ttl),
        .tx_udp_ip_source_ip        (src_ip),
        .tx_udp_ip_dest_ip          (dst_ip),
        .tx_udp_source_port         (src_port),
        .tx_udp_dest_port           (dst_port),
        .tx_udp_length              (udp_len),
        .tx_udp_checksum            (csum),
        .tx_udp_payload_axis_tdata  (pay_tdata),
        .tx_udp_payload_axis_tvalid (pay_tvalid),
        .tx_udp_payload_axis_tready (pay_tready),
        .tx_udp_payload_axis_tlast  (pay_tlast),
        .tx_udp_payload_axis_tuser  (pay_tuser),
        .frame_count                (frame_count)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_fc = 32'd0;
    bit          fc_pending = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp_word(input logic [63:0] d, input bit last);
        for (int b = 0; b < 8; b++) begin
            exp_q.push_back({d[8*b +: 8], (last && b == 7)});
        end
    endtask

    function automatic logic [63:0] frame_word(input logic [7:0] base, input int unsigned k);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) begin
            w[8*b +: 8] = base + 8'(8 * k + b);
        end
        return w;
    endfunction

    // Present one word and hold it until the DUT accepts it.
    task automatic push_word(input logic [63:0] d, input bit last);
        int unsigned n = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (!s_tready) begin
            check_eq("s_tready_timeout", 64'(s_tready), 64'd1);
        end else begin
            push_exp_word(d, last);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int unsigned k = 0; k < W; k++) begin
            push_word(frame_word(base, k), (k == W - 1));
        end
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || fc_pending) && n < 400) begin
            n++;
            @(negedge clk);
        end
        check_eq("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Monitor: header fields, payload bytes against the scoreboard, frame_count.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fc_pending) begin
                    check_eq("frame_count", 64'(frame_count), 64'(model_fc));
                    fc_pending = 1'b0;
                end
                if (hdr_valid && hdr_ready) begin
                    check_eq("hdr_len", 64'(udp_len), 64'(EXP_LEN));
                    check_eq("hdr_ip", {src_ip, dst_ip},
                             {8'd192, 8'd168, 8'd1, 8'd128, 8'd192, 8'd168, 8'd1, 8'd100});
                    check_eq("hdr_port", {src_port, dst_port}, {16'd1234, 16'd1234});
                    check_eq("hdr_misc", {dscp, ecn, ttl, csum}, {6'd0, 2'd0, 8'd64, 16'd0});
`ifdef UDP_ORIG_SEQNUM_EN
                    push_exp_word({32'd0, model_fc}, 1'b0);
`endif
                end
                if (pay_tvalid && pay_tready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_byte", 64'(pay_tdata), 64'hxx);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("byte", {pay_tuser, pay_tdata}, {1'b0, e.data});
                        check_eq("tlast", 64'(pay_tlast), 64'(e.last));
                        if (e.last) begin
                            model_fc   = model_fc + 32'd1;
                            fc_pending = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            toggle_ph = ~toggle_ph;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned idle_cycles;
        int unsigned n;
        bit          tlast_seen;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {s_tready, hdr_valid, pay_tvalid, pay_tlast}, 4'b0000);
        check_eq("rst_frame_count", 64'(frame_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic frame: bytes 0x00..0x0F, tlast on 0x0F, frame_count 1
        send_frame(8'h00);
        drain();

        // Header back-pressure for 10 cycles
        hdr_ready = 1'b0;
        fork
            send_frame(8'h20);
            begin
                n = 0;
                @(negedge clk);
                while (!hdr_valid && n < 100) begin
                    n++;
                    @(negedge clk);
                end
                for (int i = 0; i < 10; i++) begin
                    check_eq("hdr_stall", {hdr_valid, s_tready, pay_tvalid, udp_len},
                             {1'b1, 1'b0, 1'b0, EXP_LEN});
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                hdr_ready = 1'b1;
            end
        join
        drain();

        // Payload tready toggling every cycle
        toggle_en = 1'b1;
        send_frame(8'h40);
        drain();
        toggle_en = 1'b0;

        // Input starvation after word 1
        push_word(frame_word(8'h60, 0), (W == 1));
        idle_cycles = 0;
        tlast_seen  = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (!pay_tvalid) idle_cycles++;
            if (pay_tlast) tlast_seen = 1'b1;
        end
        check_eq("starve_tvalid_low", 64'(idle_cycles >= 5), 64'd1);
        check_eq("starve_no_tlast", 64'(tlast_seen), 64'd0);
        @(posedge clk);
        #1;
        for (int unsigned k = 1; k < W; k++) begin
            push_word(frame_word(8'h60, k), (k == W - 1));
        end
        drain();

        // Reset during byte 3 of word 1
        push_word(frame_word(8'h80, 0), (W == 1));
        n = 0;
        while (!(pay_tvalid && pay_tdata == 8'h83) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_eq("reach_byte3", 64'(pay_tdata), 64'h83);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_fc   = 32'd0;
        fc_pending = 1'b0;
        #1;
        check_eq("async_rst_outputs", {s_tready, hdr_valid, pay_tvalid, pay_tlast, frame_count},
                 {4'b0000, 32'd0});
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(8'hA0);
        drain();
        check_eq("post_rst_frame_count", 64'(frame_count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/udp_frame_originator.md
UDP_FRAME_ORIGINATOR -- requirements
Module: udp_frame_originator

Interface
REQ-001 SHALL have parameter WORDS_PER_FRAME, default 16: number of 64-bit sample words per UDP datagram, range 1..180.
REQ-002 SHALL have parameter SRC_PORT, default 1234: UDP source port.
REQ-003 SHALL have parameter DEST_PORT, default 1234: UDP destination port.
REQ-004 SHALL have parameter SRC_IP, default {8'd192,8'd168,8'd1,8'd128}: IP source address.
REQ-005 SHALL have parameter DEST_IP, default {8'd192,8'd168,8'd1,8'd100}: IP destination address.
REQ-006 SHALL have port clk  in  1: the one clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  in  1: reset, asynchronous and active-low.
REQ-008 SHALL have ports s_tdata in 64, s_tvalid in 1, s_tready out 1: AXI-S sample word input, no tlast.
REQ-009 SHALL have ports tx_udp_hdr_valid out 1, tx_udp_hdr_ready in 1: UDP header handshake.
REQ-010 SHALL have ports tx_udp_ip_dscp out 6, tx_udp_ip_ecn out 2, tx_udp_ip_ttl out 8, tx_udp_ip_source_ip out 32, tx_udp_ip_dest_ip out 32, tx_udp_source_port out 16, tx_udp_dest_port out 16, tx_udp_length out 16, tx_udp_checksum out 16.
REQ-011 SHALL have ports tx_udp_payload_axis_tdata out 8, _tvalid out 1, _tready in 1, _tlast out 1, _tuser out 1: byte payload stream.
REQ-012 SHALL have output frame_count 32: datagrams completed since reset.

Function
REQ-013 SHALL implement FSM IDLE -> HDR -> PAYLOAD -> IDLE.
REQ-014 IDLE SHALL move to HDR on the cycle s_tvalid=1; s_tready=0 in IDLE and HDR.
REQ-015 HDR SHALL hold tx_udp_hdr_valid=1 with stable fields until tx_udp_hdr_ready=1, then enter PAYLOAD next cycle.
REQ-016 Header fields SHALL be dscp=0, ecn=0, ttl=64, IPs/ports from parameters, checksum=0, length=8+8*W, where W=WORDS_PER_FRAME (plus 1 when REQ-026 active); computed at 16 bits from constants.
REQ-017 PAYLOAD SHALL load a 64-bit holding register on s_tvalid&&s_tready; s_tready=1 when register empty or its last byte is handshaking this cycle (zero-bubble back-to-back words).
REQ-018 Each word SHALL be emitted as 8 bytes, byte 0 = s_tdata[7:0] first, one byte per tvalid&&tready cycle.
REQ-019 tlast SHALL be 1 only on byte 7 of word W; after that handshake FSM returns to IDLE and frame_count increments (wraps at 2^32-1 -> 0).
REQ-020 s_tready SHALL be 0 once word W is loaded, until the next frame's PAYLOAD.
REQ-021 Input starvation mid-frame SHALL drop tvalid and stall, never truncate or emit tlast early.
REQ-022 tuser SHALL be constant 0; tdata/tlast stable while tvalid=1 and tready=0.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, holding register empty, byte/word counters 0, frame_count 0, tx_udp_hdr_valid=0, payload tvalid=0, tlast=0, s_tready=0.
REQ-024 Reset mid-frame SHALL abandon the frame; no tlast is issued; next frame starts with a fresh header.
REQ-025 Release of rst_n SHALL be synchronised internally (2-flop) before leaving IDLE.

Configuration
REQ-026 With UDP_ORIG_SEQNUM_EN defined, each payload SHALL begin with one extra 8-byte word {32'd0, frame_count}, LSB first, before sample words; length per REQ-016.
REQ-027 Without UDP_ORIG_SEQNUM_EN, payload SHALL be exactly W sample words and no sequence logic synthesised.

Structure
REQ-028 Shared package SHALL hold FSM state encoding, UDP_HDR_BYTES=8, default TTL=64 and length-computation constant function.
REQ-029 Byte serialiser (64-bit hold register, byte index, tvalid/tlast generation) SHALL be sub-module udp_word_serializer; FSM and header stay in top.

Verification
REQ-030 W=2, words 0x0706050403020100, 0x0F0E0D0C0B0A0908, tready=1 -> header length 24, payload bytes 0x00..0x0F, tlast on 0x0F, frame_count=1.
REQ-031 hdr_ready held 0 for 10 cycles -> hdr_valid stable 10 cycles, s_tready=0, no payload bytes.
REQ-032 Payload tready toggling 1/0 each cycle -> byte order and values unchanged, one byte per accepted handshake.
REQ-033 s_tvalid dropped 5 cycles after word 1 -> payload tvalid=0 for those cycles, tlast only after word W.
REQ-034 rst_n asserted during byte 3 of word 1 -> all outputs reset same cycle; next frame starts with header, frame_count=0.
REQ-035 With UDP_ORIG_SEQNUM_EN, three frames W=1 -> lengths 24, first payload bytes 0x00,0x01,0x02 per frame.
